// File: rtl/fifo_frame_reader.sv
// Frame reader: once the upstream FIFO holds a full frame, bursts FRAME_LEN samples out of it
// and streams them downstream with first/last markers through a 2-entry output buffer.
module fifo_frame_reader #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LEVEL_WIDTH = 12,
  parameter int unsigned FRAME_LEN   = 256
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_first,
  output logic                   m_last,
  output logic                   underrun,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0] FrameLen = CntW'(FRAME_LEN);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e                state_q;
  logic [CntW-1:0]       req_cnt_q;
  logic [CntW-1:0]       cap_idx_q;
  logic                  in_flight_q;
  logic                  skid_valid_q;
  logic                  skid_first_q;
  logic                  skid_last_q;
  logic [DATA_WIDTH-1:0] skid_data_q;

  logic       pop;
  logic       push;
  logic       push_first;
  logic       push_last;
  logic       out_free;
  logic       start;
  logic [1:0] occupancy;

  always_comb begin
    pop        = m_valid & m_ready;
    push       = in_flight_q;
    push_first = (cap_idx_q == '0);
    push_last  = (cap_idx_q == LastIdx);
    out_free   = !m_valid || m_ready;
    // A beat leaving this cycle frees its slot, which keeps reads flowing at one per cycle.
    occupancy  = 2'(m_valid) + 2'(skid_valid_q) + 2'(in_flight_q) - 2'(pop);
    start      = (32'(fifo_rd_water_level) >= FRAME_LEN) && !fifo_rd_empty;
    fifo_rd_en = (state_q == StBurst) && (req_cnt_q < FrameLen) && !fifo_rd_empty &&
                 (occupancy < 2'd2);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= StIdle;
      req_cnt_q    <= '0;
      cap_idx_q    <= '0;
      in_flight_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_first_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_first      <= 1'b0;
      m_last       <= 1'b0;
      underrun     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      in_flight_q <= fifo_rd_en;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StBurst;
            req_cnt_q <= '0;
          end
        end
        StBurst: begin
          if (fifo_rd_empty) begin
            underrun <= 1'b1;
          end
          if (fifo_rd_en) begin
            req_cnt_q <= req_cnt_q + CntW'(1);
            if (req_cnt_q == LastIdx) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && m_last) begin
            state_q   <= StIdle;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Frame position of each returning word; wraps on the last one so every frame restarts at 0.
      if (push) begin
        cap_idx_q <= push_last ? '0 : cap_idx_q + CntW'(1);
      end

      if (out_free) begin
        if (skid_valid_q) begin
          m_valid      <= 1'b1;
          m_data       <= skid_data_q;
          m_first      <= skid_first_q;
          m_last       <= skid_last_q;
          skid_valid_q <= push;
          if (push) begin
            skid_data_q  <= fifo_rd_data;
            skid_first_q <= push_first;
            skid_last_q  <= push_last;
          end
        end else if (push) begin
          m_valid <= 1'b1;
          m_data  <= fifo_rd_data;
          m_first <= push_first;
          m_last  <= push_last;
        end else begin
          m_valid <= 1'b0;
          m_first <= 1'b0;
          m_last  <= 1'b0;
        end
      end else if (push) begin
        // Output is stalled; the credit limit guarantees the skid entry is free here.
        skid_valid_q <= 1'b1;
        skid_data_q  <= fifo_rd_data;
        skid_first_q <= push_first;
        skid_last_q  <= push_last;
      end
    end
  end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter LEVEL_WIDTH, default 12, width of the FIFO read water level.
REQ-003 SHALL have parameter FRAME_LEN, default 256, samples per frame, legal range 2..1020.
REQ-004 SHALL have port rd_clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rd_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port fifo_rd_en  out  1  read strobe to the upstream FIFO.
REQ-007 SHALL have port fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_empty  in  1  FIFO empty flag.
REQ-009 SHALL have port fifo_rd_water_level  in  LEVEL_WIDTH  FIFO read-side occupancy.
REQ-010 SHALL have port m_valid  out  1  output sample valid.
REQ-011 SHALL have port m_ready  in  1  downstream accept.
REQ-012 SHALL have port m_data  out  DATA_WIDTH  output sample.
REQ-013 SHALL have port m_first  out  1  high on the first sample of a frame.
REQ-014 SHALL have port m_last  out  1  high on the last sample of a frame.
REQ-015 SHALL have port underrun  out  1  sticky underrun flag.
REQ-016 SHALL have port frame_cnt  out  16  count of completed frames.

Function
REQ-017 SHALL implement states IDLE, BURST, DRAIN.
REQ-018 IDLE->BURST SHALL occur when fifo_rd_water_level >= FRAME_LEN and fifo_rd_empty = 0; the request counter is cleared on entry.
REQ-019 In BURST, fifo_rd_en SHALL be 1 only when requests issued < FRAME_LEN, fifo_rd_empty = 0, and (entries buffered + reads in flight) < 2.
REQ-020 fifo_rd_en SHALL never be 1 while fifo_rd_empty = 1, and SHALL be 0 in IDLE and DRAIN.
REQ-021 Each returned word SHALL be captured into a 2-entry output buffer 1 cycle after its fifo_rd_en; order SHALL be preserved.
REQ-022 A beat SHALL transfer on m_valid & m_ready; m_data, m_first and m_last SHALL hold stable while m_valid = 1 and m_ready = 0.
REQ-023 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain 1 sample per cycle after an initial 2-cycle latency from entering BURST to the first m_valid.
REQ-024 m_first SHALL accompany beat 0 and m_last beat FRAME_LEN-1 of each frame.
REQ-025 BURST->DRAIN SHALL occur on the cycle the FRAME_LEN-th read is issued.
REQ-026 DRAIN->IDLE SHALL occur on the cycle the m_last beat transfers; frame_cnt SHALL increment by 1 on that cycle, wrapping from 0xFFFF to 0.
REQ-027 If fifo_rd_empty = 1 in BURST with requests remaining, the block SHALL stall without a read, set underrun = 1, and resume reading when empty deasserts.
REQ-028 underrun SHALL stay 1 until rd_rst.
REQ-029 The block SHALL not return to IDLE on an underrun; the frame always completes with exactly FRAME_LEN beats.
REQ-030 m_ready = 0 SHALL throttle fifo_rd_en through the 2-entry credit limit, and no sample SHALL be dropped or duplicated.

Reset
REQ-031 While rd_rst = 1, at the next edge: state = IDLE, buffer empty, counters 0, fifo_rd_en = 0, m_valid = 0, m_first = 0, m_last = 0, m_data = 0, underrun = 0, frame_cnt = 0.
REQ-032 rd_rst asserted mid-frame SHALL abandon the frame; any in-flight FIFO word returning the cycle after reset SHALL be discarded.

Verification
REQ-033 Level 255 then 256, FRAME_LEN = 256, m_ready = 1 -> no read at level 255; exactly 256 reads, 256 beats in order, m_first on beat 0, m_last on beat 255, frame_cnt = 1.
REQ-034 m_ready toggled in a random 50% pattern over a full frame -> m_data stable on every stalled beat, fifo_rd_en never exceeds the 2-credit limit, output matches input sequence.
REQ-035 fifo_rd_empty forced to 1 for 10 cycles after 100 reads -> no fifo_rd_en during the gap, underrun = 1, frame finishes with 256 beats, underrun still 1 afterward.
REQ-036 rd_rst pulsed for 1 cycle at beat 50 -> all outputs at reset values the next cycle; the next frame starts with m_first on a fresh sample.
REQ-037 Two back-to-back frames with level >= 512 -> DRAIN->IDLE->BURST with no lost sample; frame_cnt = 2.
REQ-038 frame_cnt preloaded by running 65536 frames (or by force) -> wraps to 0.
